// File: rtl/fetch_stage.sv
// fetch_stage: credit-limited in-order instruction fetch with response queue and redirect flush.
// Define FETCH_PERF_CNT_EN to add perf_fetched/perf_dropped counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
`endif
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 3;
  logic [31:0] r_fetch_pc, r_rsp_pc;
  logic [CW-1:0] r_out, r_drop, r_cnt;
  logic [AW-1:0] r_wp, r_rp;
  logic [63:0] r_q [QDEPTH];
  logic w_req_fire, w_discard, w_push, w_pop;
  logic [31:0] w_redir_pc;
  assign w_redir_pc = {redirect_pc[31:2], 2'b00};
  // stale responses still hold credit so they can never overflow the queue
  assign imem_req_valid = !rst && !redirect_valid && (r_out + r_cnt + r_drop < CW'(QDEPTH));
  assign imem_req_addr = r_fetch_pc;
  assign w_req_fire = imem_req_valid && imem_req_ready;
  assign w_discard = imem_rsp_valid && (redirect_valid || r_drop != '0);
  assign w_push = imem_rsp_valid && !w_discard;
  assign inst_valid = r_cnt != '0;
  assign w_pop = inst_valid && inst_ready;
  assign inst_data = r_q[r_rp][31:0];
  assign inst_pc = r_q[r_rp][63:32];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc <= RESET_PC;
      r_out <= '0;
      r_drop <= '0;
      r_cnt <= '0;
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      r_out <= r_out + CW'(w_req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        r_fetch_pc <= w_redir_pc;
        r_rsp_pc <= w_redir_pc;
        r_drop <= r_out - CW'(imem_rsp_valid);
        r_cnt <= '0;
        r_wp <= '0;
        r_rp <= '0;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_discard) r_drop <= r_drop - CW'(1);
        if (w_push) begin
          r_q[r_wp] <= {r_rsp_pc, imem_rsp_data};
          r_wp <= r_wp + AW'(1);
          r_rsp_pc <= r_rsp_pc + 32'd4;
        end
        if (w_pop) r_rp <= r_rp + AW'(1);
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (!rst && !redirect_valid)
      assert (!(w_push && !w_pop && r_cnt == CW'(QDEPTH))) else $error("push into full instruction queue");
`endif
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      if (w_pop) perf_fetched <= perf_fetched + 32'd1;
      if (w_discard) perf_dropped <= perf_dropped + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, redirect corner sequence and randomized run against a
// queue-based reference model of outstanding requests and decoded instructions.
module tb_fetch_stage;
  localparam int QD = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  logic clk = 1'b0, rst = 1'b1;
  logic imem_req_valid, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
  logic [31:0] imem_req_addr, imem_rsp_data = '0, redirect_pc = '0, inst_data, inst_pc;
  logic redirect_valid = 1'b0, inst_valid, inst_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif
  always #5 clk = ~clk;
  fetch_stage #(.RESET_PC(RST_PC), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );
  typedef struct {logic [31:0] addr; bit stale; int due;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] data;} ent_t;
  typedef struct {bit r; bit rr; bit ir; bit rd; logic [31:0] rpc; bit rv; logic [31:0] a; bit iv; logic [31:0] p;} vec_t;
  req_t uq[$];
  ent_t iq[$];
  vec_t v[$];
  logic [31:0] m_fpc = RST_PC, m_fetched = '0, m_dropped = '0, s_rpc;
  int cyc = 0, errs = 0, checks = 0, lat_lo = 1, lat_hi = 1;
  bit rnd_rsp = 0, s_r, s_rd, s_rsp, s_fire, s_pop;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic vec_t mk(bit r, bit rr, bit ir, bit rd, logic [31:0] rpc, bit rv, logic [31:0] a, bit iv, logic [31:0] p);
    vec_t t;
    t.r = r; t.rr = rr; t.ir = ir; t.rd = rd; t.rpc = rpc; t.rv = rv; t.a = a; t.iv = iv; t.p = p;
    return t;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic drive_check(input bit r, input bit rr, input bit ir, input bit rd, input logic [31:0] rpc, input bit en);
    int stale_n;
    bit e_rv;
    rst = r; imem_req_ready = rr; inst_ready = ir; redirect_valid = rd; redirect_pc = rpc;
    s_rsp = !r && uq.size() > 0 && uq[0].due <= cyc && (!rnd_rsp || $urandom_range(3) != 0);
    imem_rsp_valid = s_rsp;
    imem_rsp_data = s_rsp ? mem(uq[0].addr) : $urandom;
    stale_n = 0;
    foreach (uq[i]) stale_n += int'(uq[i].stale);
    e_rv = !r && !rd && (uq.size() + iq.size() + stale_n < QD);
    #1;
    if (en) begin
      chk("req_valid", 32'(imem_req_valid), 32'(e_rv));
      if (e_rv) chk("req_addr", imem_req_addr, m_fpc);
      chk("inst_valid", 32'(inst_valid), 32'(iq.size() > 0));
      if (iq.size() > 0) begin
        chk("inst_pc", inst_pc, iq[0].pc);
        chk("inst_data", inst_data, iq[0].data);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_dropped", perf_dropped, m_dropped);
`endif
    end
    s_r = r; s_rd = rd; s_rpc = rpc;
    s_fire = e_rv && rr;
    s_pop = iq.size() > 0 && ir;
  endtask

  task automatic advance();
    req_t h;
    @(posedge clk);
    if (s_r) begin
      uq.delete(); iq.delete();
      m_fpc = RST_PC; m_fetched = '0; m_dropped = '0;
    end else begin
      if (s_pop) begin
        void'(iq.pop_front());
        m_fetched++;
      end
      if (s_rsp) begin
        h = uq.pop_front();
        if (s_rd || h.stale) m_dropped++;
        else iq.push_back('{h.addr, mem(h.addr)});
      end
      if (s_rd) begin
        iq.delete();
        foreach (uq[i]) uq[i].stale = 1;
        m_fpc = {s_rpc[31:2], 2'b00};
      end else if (s_fire) begin
        uq.push_back('{m_fpc, 1'b0, cyc + int'($urandom_range(lat_hi, lat_lo))});
        m_fpc += 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic cycle(input bit r, input bit rr, input bit ir, input bit rd, input logic [31:0] rpc);
    drive_check(r, rr, ir, rd, rpc, 1'b1);
    advance();
  endtask

  initial begin
    logic [31:0] first_pc;
    // reset, stream, queue-full stall, request hold, redirect with response+pop, reset while full
    v.push_back(mk(1,1,1,0,0, 0,0,     0,0));
    v.push_back(mk(0,1,1,0,0, 1,'h0,   0,0));
    v.push_back(mk(0,1,1,0,0, 1,'h4,   0,0));
    v.push_back(mk(0,1,1,0,0, 0,0,     1,'h0));
    v.push_back(mk(0,1,1,0,0, 1,'h8,   1,'h4));
    v.push_back(mk(0,1,1,0,0, 1,'hC,   0,0));
    v.push_back(mk(0,1,1,0,0, 0,0,     1,'h8));
    v.push_back(mk(0,1,0,0,0, 1,'h10,  1,'hC));
    v.push_back(mk(0,1,0,0,0, 0,0,     1,'hC));
    v.push_back(mk(0,1,0,0,0, 0,0,     1,'hC));
    v.push_back(mk(0,1,1,0,0, 0,0,     1,'hC));
    v.push_back(mk(0,1,1,0,0, 1,'h14,  1,'h10));
    v.push_back(mk(0,0,1,0,0, 1,'h18,  0,0));
    v.push_back(mk(0,0,1,0,0, 1,'h18,  1,'h14));
    v.push_back(mk(0,0,1,0,0, 1,'h18,  0,0));
    v.push_back(mk(0,1,1,0,0, 1,'h18,  0,0));
    v.push_back(mk(0,1,1,0,0, 1,'h1C,  0,0));
    v.push_back(mk(0,1,1,1,'h103, 0,0, 1,'h18));
    v.push_back(mk(0,1,1,0,0, 1,'h100, 0,0));
    v.push_back(mk(0,1,1,0,0, 1,'h104, 0,0));
    v.push_back(mk(0,1,1,0,0, 0,0,     1,'h100));
    v.push_back(mk(0,1,0,0,0, 1,'h108, 1,'h104));
    v.push_back(mk(0,1,0,0,0, 0,0,     1,'h104));
    v.push_back(mk(0,1,0,0,0, 0,0,     1,'h104));
    v.push_back(mk(1,1,0,0,0, 0,0,     1,'h104));
    v.push_back(mk(0,1,1,0,0, 1,'h0,   0,0));
    v.push_back(mk(0,1,1,0,0, 1,'h4,   0,0));
    v.push_back(mk(0,1,1,0,0, 0,0,     1,'h0));
    drive_check(1, 0, 0, 0, 0, 1'b0);
    advance();
    foreach (v[k]) begin
      drive_check(v[k].r, v[k].rr, v[k].ir, v[k].rd, v[k].rpc, 1'b1);
      chk($sformatf("vec%0d_req_valid", k), 32'(imem_req_valid), 32'(v[k].rv));
      if (v[k].rv) chk($sformatf("vec%0d_req_addr", k), imem_req_addr, v[k].a);
      chk($sformatf("vec%0d_inst_valid", k), 32'(inst_valid), 32'(v[k].iv));
      if (v[k].iv) chk($sformatf("vec%0d_inst_pc", k), inst_pc, v[k].p);
      advance();
    end
    // two requests in flight (0x10, 0x14) when redirected to 0x103
    lat_lo = 3; lat_hi = 3;
    cycle(1, 1, 1, 0, 0);
    cycle(0, 1, 1, 1, 32'h10);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 0, 0);
    chk("two_outstanding_stall", 32'(imem_req_valid), 32'(0));
    cycle(0, 1, 1, 1, 32'h103);
    first_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 20 && first_pc == 32'hFFFF_FFFF; i++) begin
      drive_check(0, 1, 1, 0, 0, 1'b1);
      if (inst_valid) first_pc = inst_pc;
      advance();
    end
    chk("redirect_first_pc", first_pc, 32'h100);
    // randomized traffic
    lat_lo = 1; lat_hi = 3; rnd_rsp = 1;
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(199) == 0, $urandom_range(3) != 0, $urandom_range(9) < 7,
            $urandom_range(15) == 0, $urandom);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
